// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// forward-select codes and the operand forwarding priority function.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
    localparam logic [15:0] STALL_CNT_MAX   = 16'hFFFF;

    // The Memory stage holds the newer value, so it wins over Writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// ALU operand forwarding for both Execute-stage source operands.
module forward_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    // Operand select for source A and source B
    always_comb begin
        ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait FSM with timeout, branch flush,
// load-use stall, stall-cycle performance counter and operand forwarding.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemAccessM,
    input  logic        DMemReadyM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [15:0] StallCycles
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    hz_state_t   state_r;
    hz_state_t   state_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_s;
    logic [15:0] stall_cnt_r;
    logic        mem_wait_s;
    logic        mem_stall_s;
    logic        load_use_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;
    logic        stall_f_s;
    logic        stall_d_s;
    logic        stall_e_s;
    logic        stall_m_s;
    logic        flush_d_s;
    logic        flush_e_s;
    logic        flush_w_s;

    forward_unit u_forward_unit (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a_s),
        .ForwardBE (fwd_b_s)
    );

    assign mem_wait_s = MemAccessM & ~DMemReadyM;
    assign load_use_s = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Memory-wait FSM next state and wait counter
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        mem_stall_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_wait_s) begin
                    mem_stall_s = 1'b1;
                    state_s     = MEM_WAIT;
                    wait_cnt_s  = 8'd1;
                end else begin
                    wait_cnt_s  = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_wait_s) begin
                    mem_stall_s = 1'b1;
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_s = TIMEOUT;
                    end else begin
                        wait_cnt_s = wait_cnt_r + 8'd1;
                    end
                end else begin
                    state_s    = RUN;
                    wait_cnt_s = 8'd0;
                end
            end
            TIMEOUT: begin
                mem_stall_s = 1'b1;
            end
            default: begin
                state_s    = RUN;
                wait_cnt_s = 8'd0;
            end
        endcase
    end

    // Stall/flush priority: timeout/memory wait, then branch flush, then load-use
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        if (rst) begin
            stall_f_s = 1'b0;
        end else if (mem_stall_s) begin
            // A taken branch stays in Execute and is re-evaluated once memory responds.
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (PCSrcE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (load_use_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            flush_w_s = 1'b0;
        end
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_f_s && (stall_cnt_r != STALL_CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign StallF      = stall_f_s;
    assign StallD      = stall_d_s;
    assign StallE      = stall_e_s;
    assign StallM      = stall_m_s;
    assign FlushD      = flush_d_s;
    assign FlushE      = flush_e_s;
    assign FlushW      = flush_w_s;
    assign ForwardAE   = rst ? FWD_RF : fwd_a_s;
    assign ForwardBE   = rst ? FWD_RF : fwd_b_s;
    assign MemTimeout  = (state_r == TIMEOUT);
    assign StallCycles = stall_cnt_r;

endmodule
